// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// mem_req_arbiter_pkg - shared defaults and helpers for the memory arbiter
// rev 1.0
// ==========================================================================
package mem_req_arbiter_pkg;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_ADDR_W   = 25;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_OUT  = 8;
  localparam int DEF_CH_IDX_W = $clog2(DEF_NUM_CH);

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_tag_fifo.sv
`default_nettype none
// ==========================================================================
// tag_fifo - in-order FIFO of channel tags for outstanding reads
// rev 1.0
// ==========================================================================
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_req_arbiter - N-channel arbiter onto one memory port with read routing
// rev 1.0
// ==========================================================================
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT,
  parameter int RR_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     err_underflow
);

  localparam int IDX_W = ch_idx_w(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];
  logic [NUM_CH-1:0] eligible;
  logic              read_ok;
  logic              load;
  logic              any_elig;
  logic              accept;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  next_ptr;
  logic [IDX_W-1:0]  cand_idx;
  int                cand;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tag_push;
  logic              tag_pop;
  logic [IDX_W-1:0]  tag_head;
  logic [CNT_W-1:0]  tag_count;

  // Count is taken before this cycle's pop, so a full FIFO never admits a read
  // in the same cycle a return frees a slot.
  assign read_ok = !fifo_full && (tag_count < CNT_W'(MAX_OUT));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = ch_wdata[g*DATA_W +: DATA_W];
    assign eligible[g]  = ch_valid[g] && (ch_we[g] || read_ok);
  end

  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (RR_MODE != 0) ? int'(ptr) + k : k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!any_elig && eligible[cand_idx]) begin
        any_elig = 1'b1;
        winner   = cand_idx;
      end
    end
  end

  assign load     = !mem_req || mem_ready;
  assign accept   = load && any_elig;
  assign ch_ready = accept ? (NUM_CH'(1) << winner) : '0;
  assign next_ptr = (winner == IDX_W'(NUM_CH - 1)) ? '0 : winner + IDX_W'(1);
  assign tag_push = accept && !ch_we[winner];
  assign tag_pop  = mem_rvalid && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
    end else if (accept) begin
      mem_req   <= 1'b1;
      mem_we    <= ch_we[winner];
      mem_addr  <= addr_arr[winner];
      mem_wdata <= wdata_arr[winner];
      if (RR_MODE != 0) ptr <= next_ptr;
    end else if (mem_ready) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ch_rvalid     <= '0;
      ch_rdata      <= '0;
      err_underflow <= 1'b0;
    end else begin
      ch_rvalid <= '0;
      if (tag_pop) begin
        ch_rvalid <= NUM_CH'(1) << tag_head;
        ch_rdata  <= mem_rdata;
      end
      if (mem_rvalid && fifo_empty) err_underflow <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (tag_push),
    .push_data (winner),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (tag_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// tb_mem_req_arbiter - scoreboard bench for round-robin and fixed arbiters
// rev 1.0
// ==========================================================================
module tb_mem_req_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 25;
  localparam int DW  = 32;
  localparam int MO  = 8;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;

  logic [NCH-1:0] rr_ready, rr_rvalid, fx_ready, fx_rvalid;
  logic [DW-1:0]  rr_rdata, rr_wdata, fx_rdata, fx_wdata;
  logic [AW-1:0]  rr_addr, fx_addr;
  logic           rr_req, rr_we, rr_err, fx_req, fx_we, fx_err;

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_b(rst_b), .ch_valid(ch_valid), .ch_ready(rr_ready), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rvalid(rr_rvalid), .ch_rdata(rr_rdata),
    .mem_req(rr_req), .mem_ready(mem_ready), .mem_we(rr_we), .mem_addr(rr_addr),
    .mem_wdata(rr_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err_underflow(rr_err)
  );

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .RR_MODE(0)) u_fx (
    .clk(clk), .rst_b(rst_b), .ch_valid(ch_valid), .ch_ready(fx_ready), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rvalid(fx_rvalid), .ch_rdata(fx_rdata),
    .mem_req(fx_req), .mem_ready(mem_ready), .mem_we(fx_we), .mem_addr(fx_addr),
    .mem_wdata(fx_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err_underflow(fx_err)
  );

  typedef struct {
    int            due;
    logic          strict;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int             due;
    logic [NCH-1:0] onehot;
    logic [DW-1:0]  data;
  } rd_exp_t;

  mem_exp_t memq[$];
  rd_exp_t  rdq[$];
  mem_exp_t me;
  rd_exp_t  re;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rr_seq[5] = '{0, 2, 0, 2, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard for the round-robin instance: memory-side issues and read returns.
  always @(negedge clk) begin
    if (rst_b) begin
      if (rr_req && mem_ready) begin
        if (memq.size() == 0) begin
          chk("mem_unexpected", 64'(rr_req), 64'(0));
        end else begin
          me = memq.pop_front();
          if (me.strict) chk("mem_due", 64'(cyc), 64'(me.due));
          chk("mem_we", 64'(rr_we), 64'(me.we));
          chk("mem_addr", 64'(rr_addr), 64'(me.addr));
          if (me.we) chk("mem_wdata", 64'(rr_wdata), 64'(me.wdata));
        end
      end else if (memq.size() != 0 && memq[0].strict && memq[0].due == cyc) begin
        chk("mem_missing", 64'(rr_req), 64'(1));
        void'(memq.pop_front());
      end

      if (rr_rvalid != '0) begin
        if (rdq.size() == 0) begin
          chk("rd_unexpected", 64'(rr_rvalid), 64'(0));
        end else begin
          re = rdq.pop_front();
          chk("rd_due", 64'(cyc), 64'(re.due));
          chk("rd_onehot", 64'(rr_rvalid), 64'(re.onehot));
          chk("rd_data", 64'(rr_rdata), 64'(re.data));
        end
      end else if (rdq.size() != 0 && rdq[0].due == cyc) begin
        chk("rd_missing", 64'(rr_rvalid), 64'(rdq[0].onehot));
        void'(rdq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_valid   = '0;
    ch_we      = '0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic set_ch(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_we[i]             = we;
    ch_addr[i*AW +: AW]  = a;
    ch_wdata[i*DW +: DW] = d;
  endtask

  task automatic exp_mem(input logic strict, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_exp_t e;
    e.due    = cyc + 1;
    e.strict = strict;
    e.we     = we;
    e.addr   = a;
    e.wdata  = d;
    memq.push_back(e);
  endtask

  task automatic ret(input int ch, input logic [DW-1:0] d);
    rd_exp_t e;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    e.due      = cyc + 1;
    e.onehot   = NCH'(1) << ch;
    e.data     = d;
    rdq.push_back(e);
  endtask

  task automatic do_reset();
    idle_inputs();
    step();
    chk("memq_drained", 64'(memq.size()), 64'(0));
    chk("rdq_drained", 64'(rdq.size()), 64'(0));
    memq.delete();
    rdq.delete();
    rst_b = 1'b0;
    step();
    step();
    rst_b = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 64'(rr_req), 64'(0));
    chk({tag, "_we"}, 64'(rr_we), 64'(0));
    chk({tag, "_addr"}, 64'(rr_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(rr_wdata), 64'(0));
    chk({tag, "_rvalid"}, 64'(rr_rvalid), 64'(0));
    chk({tag, "_rdata"}, 64'(rr_rdata), 64'(0));
    chk({tag, "_err"}, 64'(rr_err), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ch_addr  = '0;
    ch_wdata = '0;
    idle_inputs();
    rst_b = 1'b0;
    step();
    step();
    @(negedge clk);
    chk_zero("reset");
    chk("reset_ready", 64'(rr_ready), 64'(0));
    chk("reset_fx_req", 64'(fx_req), 64'(0));
    step();
    rst_b = 1'b1;

    // Round-robin rotation with all channels reading.
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, AW'(32'h100 + i), '0);
    ch_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_mem(1'b1, 1'b0, AW'(32'h100 + (k % 4)), '0);
      @(negedge clk);
      chk("rr_rotate", 64'(rr_ready), 64'(NCH'(1) << (k % 4)));
      step();
    end
    do_reset();

    // Fixed priority vs round-robin with ch0 and ch2 writing.
    set_ch(0, 1'b1, AW'(32'h200), 32'h1000);
    set_ch(2, 1'b1, AW'(32'h202), 32'h1002);
    ch_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) ch_valid = 4'b0100;
      exp_mem(1'b1, 1'b1, AW'(32'h200 + rr_seq[k]), 32'h1000 + rr_seq[k]);
      @(negedge clk);
      chk("fx_grant", 64'(fx_ready), (k < 3) ? 64'h1 : 64'h4);
      chk("rr_grant", 64'(rr_ready), 64'(NCH'(1) << rr_seq[k]));
      step();
    end
    do_reset();

    // Backpressure hold on a ch1 write.
    mem_ready = 1'b0;
    set_ch(1, 1'b1, 25'h12345, 32'hDEADBEEF);
    ch_valid = 4'b0010;
    exp_mem(1'b0, 1'b1, 25'h12345, 32'hDEADBEEF);
    @(negedge clk);
    chk("bp_first_accept", 64'(rr_ready), 64'h2);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 64'(rr_ready), 64'(0));
      chk("bp_req", 64'(rr_req), 64'(1));
      chk("bp_addr", 64'(rr_addr), 64'h12345);
      chk("bp_wdata", 64'(rr_wdata), 64'hDEADBEEF);
      step();
    end
    ch_valid  = '0;
    mem_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_released", 64'(rr_req), 64'(0));
    do_reset();

    // Outstanding-read limit: writes pass, reads wait for a return.
    for (int k = 0; k < MO; k++) begin
      set_ch(0, 1'b0, AW'(32'h300 + k), '0);
      ch_valid = 4'b0001;
      exp_mem(1'b1, 1'b0, AW'(32'h300 + k), '0);
      @(negedge clk);
      chk("fill_read", 64'(rr_ready), 64'h1);
      step();
    end
    set_ch(1, 1'b1, AW'(32'h310), 32'hCAFE0001);
    ch_valid = 4'b0011;
    exp_mem(1'b1, 1'b1, AW'(32'h310), 32'hCAFE0001);
    @(negedge clk);
    chk("full_write_ok", 64'(rr_ready), 64'h2);
    step();
    ch_valid = 4'b0001;
    @(negedge clk);
    chk("full_read_blocked", 64'(rr_ready), 64'(0));
    step();
    ret(0, 32'h55);
    @(negedge clk);
    chk("no_passthrough", 64'(rr_ready), 64'(0));
    step();
    mem_rvalid = 1'b0;
    exp_mem(1'b1, 1'b0, AW'(32'h307), '0);
    @(negedge clk);
    chk("read_after_pop", 64'(rr_ready), 64'h1);
    step();
    do_reset();

    // In-order return routing: ch3, ch1, ch3.
    set_ch(3, 1'b0, AW'(32'h403), '0);
    set_ch(1, 1'b0, AW'(32'h401), '0);
    ch_valid = 4'b1000;
    exp_mem(1'b1, 1'b0, AW'(32'h403), '0);
    @(negedge clk);
    chk("route_grant_a", 64'(rr_ready), 64'h8);
    step();
    ch_valid = 4'b0010;
    exp_mem(1'b1, 1'b0, AW'(32'h401), '0);
    @(negedge clk);
    chk("route_grant_b", 64'(rr_ready), 64'h2);
    step();
    ch_valid = 4'b1000;
    exp_mem(1'b1, 1'b0, AW'(32'h403), '0);
    @(negedge clk);
    chk("route_grant_c", 64'(rr_ready), 64'h8);
    step();
    ch_valid = '0;
    step();
    ret(3, 32'hA);
    step();
    ret(1, 32'hB);
    step();
    ret(3, 32'hC);
    step();
    mem_rvalid = 1'b0;
    step();
    @(negedge clk);
    chk("route_no_err", 64'(rr_err), 64'(0));
    do_reset();

    // Reset with reads outstanding, then a stray return.
    for (int k = 0; k < 3; k++) begin
      set_ch(k, 1'b0, AW'(32'h500 + k), '0);
      ch_valid = NCH'(1) << k;
      exp_mem(1'b1, 1'b0, AW'(32'h500 + k), '0);
      @(negedge clk);
      chk("pre_reset_grant", 64'(rr_ready), 64'(NCH'(1) << k));
      step();
    end
    ch_valid = '0;
    step();
    step();
    chk("pre_reset_memq", 64'(memq.size()), 64'(0));
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77;
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("underflow_set", 64'(rr_err), 64'(1));
    chk("underflow_no_rvalid", 64'(rr_rvalid), 64'(0));
    chk("underflow_fx", 64'(fx_err), 64'(1));
    step();
    @(negedge clk);
    chk("underflow_sticky", 64'(rr_err), 64'(1));
    chk("final_memq", 64'(memq.size()), 64'(0));
    chk("final_rdq", 64'(rdq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
